// File: rtl/uart_depacketizer_dig_if.sv
// UART depacketizer consumer-side bundle.
// Line input, read port, error clear and status.
interface uart_depacketizer_dig_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int NW = $clog2(FIFO_DEPTH) + 1;

  logic          serial_in;
  logic          rd_en;
  logic          err_clr;
  logic [7:0]    data_out;
  logic          data_out_valid;
  logic          fifo_empty;
  logic          fifo_full;
  logic [NW-1:0] fifo_count;
  logic          rx_busy;
  logic          frame_err;
  logic          overrun;

  modport master (
    output serial_in, rd_en, err_clr,
    input  data_out, data_out_valid, fifo_empty,
    input  fifo_full, fifo_count, rx_busy,
    input  frame_err, overrun
  );

  modport slave (
    input  serial_in, rd_en, err_clr,
    output data_out, data_out_valid, fifo_empty,
    output fifo_full, fifo_count, rx_busy,
    output frame_err, overrun
  );
endinterface

// File: rtl/uart_depacketizer_dig.sv
// UART 8N1 receiver with byte FIFO and sticky
// framing/overrun flags.
module uart_depacketizer_dig #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input logic clk,
  input logic rst,
  uart_depacketizer_dig_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_HIGH
  } state_t;

  logic s1_q, s2_q, rxs;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d;
  logic busy_q;
  logic push_req, ovr_set, fe_set;

  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] num_q, num_d;
  logic [7:0] dout_q;
  logic dv_q, fe_q, ov_q;
  logic full, empty, push, pop;

  assign rxs   = s2_q;
  assign full  = (num_q == FULL);
  assign empty = (num_q == '0);
  assign push  = push_req && !full;
  assign pop   = bus.rd_en && !empty;

  // two-flop synchroniser on the asynchronous line
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= bus.serial_in;
      s2_q <= s1_q;
    end
  end

  // receive FSM next-state and byte assembly
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    idx_d    = idx_q;
    sh_d     = sh_q;
    push_req = 1'b0;
    ovr_set  = 1'b0;
    fe_set   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (cnt_q == MID) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          sh_d[idx_q] = rxs;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (rxs) begin
            push_req = 1'b1;
            ovr_set  = full;
            state_d  = IDLE;
          end else begin
            fe_set  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // receive FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // occupancy follows accepted push and pop
  always_comb begin
    num_d = num_q;
    if (push && !pop) num_d = num_q + (AW + 1)'(1);
    if (pop && !push) num_d = num_q - (AW + 1)'(1);
  end

  // FIFO pointers, count and read register
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q   <= '0;
      rp_q   <= '0;
      num_q  <= '0;
      dout_q <= '0;
      dv_q   <= 1'b0;
    end else begin
      num_q <= num_d;
      dv_q  <= pop;
      if (push) wp_q <= wp_q + AW'(1);
      if (pop) begin
        rp_q   <= rp_q + AW'(1);
        dout_q <= mem_q[rp_q];
      end
    end
  end

  // FIFO storage, contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= sh_q;
  end

  // sticky error flags, a new error beats a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      fe_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      if (fe_set) fe_q <= 1'b1;
      else if (bus.err_clr) fe_q <= 1'b0;
      if (ovr_set) ov_q <= 1'b1;
      else if (bus.err_clr) ov_q <= 1'b0;
    end
  end

  assign bus.data_out       = dout_q;
  assign bus.data_out_valid = dv_q;
  assign bus.fifo_empty     = empty;
  assign bus.fifo_full      = full;
  assign bus.fifo_count     = num_q;
  assign bus.rx_busy        = busy_q;
  assign bus.frame_err      = fe_q;
  assign bus.overrun        = ov_q;
endmodule
